// File: rtl/key_operand_loader.sv
// Keypad front end: debounces scanner hits, decodes digits/CLEAR/ENTER and builds two
// decimal operands for the serial adder. Define KEY_ECHO_EN to add key_event/key_code.
module key_operand_loader #(
    parameter int WIDTH          = 8,
    parameter int STABLE_HITS    = 2,
    parameter int RELEASE_CYCLES = 32,
    parameter int MAX_DIGITS     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag,
    input  logic [4:0]       code,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             entry_b,
    output logic             overflow
`ifdef KEY_ECHO_EN
    ,
    output logic             key_event,
    output logic [4:0]       key_code
`endif
);

    localparam int HW = $clog2(STABLE_HITS + 1);
    localparam int QW = $clog2(RELEASE_CYCLES + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);

    localparam logic [HW-1:0] HIT_MAX   = HW'(STABLE_HITS);
    localparam logic [QW-1:0] QUIET_MAX = QW'(RELEASE_CYCLES);
    localparam logic [DW-1:0] DIG_MAX   = DW'(MAX_DIGITS);

    localparam logic [4:0] CODE_CLEAR = 5'd12;
    localparam logic [4:0] CODE_ENTER = 5'd16;

    // state    | meaning
    // ENTER_A  | keying operand A
    // ENTER_B  | keying operand B
    // SEND     | operands offered to the adder, keys discarded
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       cand_q, cand_d;
    logic [HW-1:0]    hit_q, hit_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic             held_q, held_d;
    logic             event_q, event_d;
    logic [4:0]       ev_code_q, ev_code_d;

    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic             entry_b_q, entry_b_d;
    logic             overflow_q, overflow_d;
    logic [DW-1:0]    digit_cnt_q, digit_cnt_d;

    logic [WIDTH-1:0] acc_sel;
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] acc_next;
    logic             is_digit;
    logic             digit_ok;

    always_comb begin
        cand_d    = cand_q;
        hit_d     = hit_q;
        quiet_d   = quiet_q;
        held_d    = held_q;
        event_d   = 1'b0;
        ev_code_d = ev_code_q;

        if (flag) begin
            quiet_d = '0;
            if (code == cand_q) begin
                if (hit_q != HIT_MAX) begin
                    hit_d = hit_q + 1'b1;
                end
            end else begin
                cand_d = code;
                hit_d  = HW'(1);
            end
            // Only the first stable press after a release counts; rollover is ignored.
            if (!held_q && (hit_d == HIT_MAX)) begin
                event_d   = 1'b1;
                held_d    = 1'b1;
                ev_code_d = code;
            end
        end else begin
            if (quiet_q != QUIET_MAX) begin
                quiet_d = quiet_q + 1'b1;
            end
            if (quiet_d == QUIET_MAX) begin
                held_d = 1'b0;
                hit_d  = '0;
                cand_d = '0;
            end
        end
    end

    assign is_digit = (ev_code_q != 5'd0) && (ev_code_q <= 5'd9);
    assign digit_ok = is_digit && (digit_cnt_q != DIG_MAX);
    assign acc_sel  = (state_q == ENTER_B) ? op_b_q : op_a_q;
    assign acc_ext  = {4'b0000, acc_sel};
    assign acc_next = (acc_ext << 3) + (acc_ext << 1) + (WIDTH + 4)'(ev_code_q);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_valid_d  = op_valid_q;
        entry_b_d   = entry_b_q;
        overflow_d  = overflow_q;
        digit_cnt_d = digit_cnt_q;

        case (state_q)
            ENTER_A: begin
                if (event_q) begin
                    if (digit_ok) begin
                        op_a_d      = acc_next[WIDTH-1:0];
                        digit_cnt_d = digit_cnt_q + 1'b1;
                        if (|acc_next[WIDTH+3:WIDTH]) begin
                            overflow_d = 1'b1;
                        end
                    end else if (ev_code_q == CODE_ENTER) begin
                        state_d     = ENTER_B;
                        entry_b_d   = 1'b1;
                        digit_cnt_d = '0;
                    end else if (ev_code_q == CODE_CLEAR) begin
                        op_a_d      = '0;
                        digit_cnt_d = '0;
                        overflow_d  = 1'b0;
                    end
                end
            end
            ENTER_B: begin
                if (event_q) begin
                    if (digit_ok) begin
                        op_b_d      = acc_next[WIDTH-1:0];
                        digit_cnt_d = digit_cnt_q + 1'b1;
                        if (|acc_next[WIDTH+3:WIDTH]) begin
                            overflow_d = 1'b1;
                        end
                    end else if (ev_code_q == CODE_ENTER) begin
                        state_d    = SEND;
                        op_valid_d = 1'b1;
                        entry_b_d  = 1'b0;
                    end else if (ev_code_q == CODE_CLEAR) begin
                        state_d     = ENTER_A;
                        op_a_d      = '0;
                        op_b_d      = '0;
                        digit_cnt_d = '0;
                        overflow_d  = 1'b0;
                        entry_b_d   = 1'b0;
                    end
                end
            end
            SEND: begin
                // Key events here are dropped, even one landing on the handshake edge.
                if (op_valid_q && op_ready) begin
                    state_d     = ENTER_A;
                    op_valid_d  = 1'b0;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    digit_cnt_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTER_A;
            cand_q      <= '0;
            hit_q       <= '0;
            quiet_q     <= '0;
            held_q      <= 1'b0;
            event_q     <= 1'b0;
            ev_code_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            entry_b_q   <= 1'b0;
            overflow_q  <= 1'b0;
            digit_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            hit_q       <= hit_d;
            quiet_q     <= quiet_d;
            held_q      <= held_d;
            event_q     <= event_d;
            ev_code_q   <= ev_code_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_valid_q  <= op_valid_d;
            entry_b_q   <= entry_b_d;
            overflow_q  <= overflow_d;
            digit_cnt_q <= digit_cnt_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign entry_b  = entry_b_q;
    assign overflow = overflow_q;

`ifdef KEY_ECHO_EN
    assign key_event = event_q;
    assign key_code  = ev_code_q;
`endif

endmodule

// File: tb/tb_key_operand_loader.sv
// Scoreboarded bench for key_operand_loader: directed scenarios plus random key streams
// checked against an operand-level model; transfers are checked by a separate monitor.
module tb_key_operand_loader;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flag;
    logic [4:0]   code;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         op_ready;
    logic         entry_b;
    logic         overflow;
`ifdef KEY_ECHO_EN
    logic         key_event;
    logic [4:0]   key_code;
`endif

    always #5 clk = ~clk;

    key_operand_loader #(
        .WIDTH(W), .STABLE_HITS(2), .RELEASE_CYCLES(32), .MAX_DIGITS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flag     (flag),
        .code     (code),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .entry_b  (entry_b),
        .overflow (overflow)
`ifdef KEY_ECHO_EN
        ,
        .key_event(key_event),
        .key_code (key_code)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model: operand values, digit count, phase (0 = A, 1 = B, 2 = send), sticky overflow
    int m_a, m_b, m_dc, m_st, m_ovf;
    logic [2*W:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [4:0] c);
        flag = 1'b1;
        code = c;
        tick();
        flag = 1'b0;
        code = 5'($urandom);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_dc = 0; m_st = 0; m_ovf = 0;
    endtask

    task automatic model_key(input int c);
        int v;
        if (m_st == 2) return;
        if (c >= 1 && c <= 9) begin
            if (m_dc < 3) begin
                v = ((m_st == 0) ? m_a : m_b) * 10 + c;
                if (v >= 256) m_ovf = 1;
                if (m_st == 0) m_a = v % 256; else m_b = v % 256;
                m_dc++;
            end
        end else if (c == 12) begin
            if (m_st == 1) begin
                m_b = 0;
                m_st = 0;
            end
            m_a = 0; m_dc = 0; m_ovf = 0;
        end else if (c == 16) begin
            if (m_st == 0) begin
                m_st = 1;
                m_dc = 0;
            end else begin
                m_st = 2;
                exp_q.push_back({W'(m_a), W'(m_b), 1'(m_ovf)});
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_op_a"}, 32'(op_a), m_a);
        chk({tag, "_op_b"}, 32'(op_b), m_b);
        chk({tag, "_valid"}, 32'(op_valid), (m_st == 2) ? 1 : 0);
        chk({tag, "_entry_b"}, 32'(entry_b), (m_st == 1) ? 1 : 0);
        chk({tag, "_ovf"}, 32'(overflow), m_ovf);
    endtask

    task automatic press(input logic [4:0] c, input int gap);
        pulse(c);
        quiet(gap);
        pulse(c);
        model_key(int'(c));
        quiet(34 + $urandom_range(0, 6));
    endtask

    task automatic handshake(input int delay);
        op_ready = 1'b0;
        quiet(delay);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        if (m_st == 2) begin
            m_a = 0; m_b = 0; m_dc = 0; m_st = 0; m_ovf = 0;
        end
        check_state("hs");
    endtask

    // transfer monitor
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (rst === 1'b0 && op_valid === 1'b1 && op_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL xfer_unexpected: got a=%0d b=%0d expected no transfer", op_a, op_b);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_a", 32'(op_a), 32'(e[2*W:W+1]));
                chk("xfer_b", 32'(op_b), 32'(e[W:1]));
                chk("xfer_ovf", 32'(overflow), 32'(e[0]));
            end
        end
    end

    initial begin
        #5_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int c;
        rst = 1'b1; flag = 1'b0; code = 5'd0; op_ready = 1'b0;
        model_reset();
        quiet(3);
        rst = 1'b0;
        check_state("reset");

        // repeated hits of one held key give one event, two edges after the accepting hit
        for (int i = 0; i < 10; i++) begin
            pulse(5'd3);
            if (i == 1) begin
                chk("lat_edge1", 32'(op_a), 0);
`ifdef KEY_ECHO_EN
                chk("echo_pulse", 32'(key_event), 1);
                chk("echo_code", 32'(key_code), 3);
`endif
                tick();
                chk("lat_edge2", 32'(op_a), 3);
`ifdef KEY_ECHO_EN
                chk("echo_drop", 32'(key_event), 0);
`endif
                model_key(3);
                quiet(18);
            end else begin
                quiet(19);
            end
        end
        check_state("held");
        quiet(34);
        press(5'd3, 4);
        check_state("t1_33");

        // two operands, ready held low, then transfer
        press(5'd12, 3);
        press(5'd2, 3);
        press(5'd4, 7);
        press(5'd16, 2);
        check_state("t2_enter_a");
        press(5'd6, 5);
        press(5'd16, 9);
        check_state("t2_send");
        quiet(10);
        check_state("t2_wait");
        handshake(0);

        // overflow, digit limit, clear
        press(5'd9, 2);
        press(5'd9, 2);
        press(5'd9, 2);
        check_state("t3_999");
        press(5'd1, 2);
        check_state("t3_limit");
        press(5'd12, 2);
        check_state("t3_clear");

        // single hit, alternating codes, ignored code, rollover while held
        pulse(5'd4);
        quiet(40);
        for (int i = 0; i < 8; i++) begin
            pulse((i % 2 == 0) ? 5'd4 : 5'd6);
            quiet(19);
        end
        quiet(34);
        check_state("t4_nokey");
        press(5'd10, 3);
        check_state("t4_code10");
        pulse(5'd5); quiet(3); pulse(5'd5); quiet(3);
        model_key(5);
        pulse(5'd7); quiet(3); pulse(5'd7);
        quiet(36);
        check_state("t4_rollover");

        // keys discarded in SEND, key event on the handshake edge, clear from B
        press(5'd16, 2);
        press(5'd7, 2);
        press(5'd16, 2);
        press(5'd16, 2);
        press(5'd12, 2);
        check_state("t5_send");
        pulse(5'd2);
        quiet(3);
        pulse(5'd2);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        m_a = 0; m_b = 0; m_dc = 0; m_st = 0; m_ovf = 0;
        quiet(36);
        check_state("t5_hs_event");
        press(5'd8, 2);
        press(5'd16, 2);
        press(5'd3, 2);
        press(5'd12, 2);
        check_state("t5_clear_b");

        // reset beats a pending transfer
        press(5'd1, 2);
        press(5'd16, 2);
        press(5'd2, 2);
        press(5'd16, 2);
        op_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_ready = 1'b0;
        model_reset();
        exp_q.delete();
        check_state("t6_rst");
        press(5'd9, 3);
        check_state("t6_after");
`ifdef KEY_ECHO_EN
        chk("echo_code9", 32'(key_code), 9);
`endif

        // random key streams
        for (int k = 0; k < 250; k++) begin
            if (m_st == 2 && ($urandom % 2 == 0)) handshake($urandom_range(0, 4));
            op_ready = (m_st == 0) ? ($urandom % 3 == 0) : 1'b0;
            c = int'($urandom % 100);
            if (c < 55) c = $urandom_range(1, 9);
            else if (c < 70) c = 16;
            else if (c < 78) c = 12;
            else begin
                c = $urandom_range(0, 31);
                if ((c >= 1 && c <= 9) || c == 12 || c == 16) c = 0;
            end
            press(5'(c), $urandom_range(1, 25));
            check_state("rnd");
        end
        op_ready = 1'b0;
        if (m_st == 2) handshake(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
